ddr_wr_burst_ctrl: RTL and testbench
====================================

DDR_WR_BURST_CTRL -- requirements
Module: ddr_wr_burst_ctrl

Interface
REQ-001 Parameter DATA_W, default 128, sets the app write data width in bits.
REQ-002 Parameter ADDR_W, default 28, sets the app address width in bits.
REQ-003 Parameter BL_W, default 7, sets the burst-length field width; max burst is 2^BL_W-1 beats.
REQ-004 Parameter ADDR_STEP, default 8, sets the address increment per accepted command.
REQ-005 Derived MASK_W = DATA_W/8, which is the byte-mask width.
REQ-006 One clock and one reset; reset is asynchronous and active-high: sclk  in  1  clock; rst  in  1  async active-high reset.
REQ-007 wr_cmd_start  in  1  one-cycle burst request pulse.
REQ-008 wr_cmd_bl  in  BL_W  beats in burst.
REQ-009 wr_cmd_addr  in  ADDR_W  start address.
REQ-010 wr_cmd_mask  in  MASK_W  byte mask applied to every beat, where 1 means the byte is not written.
REQ-011 data_in  in  DATA_W  user beat, valid in any cycle data_req=1.
REQ-012 data_req  out  1  beat consumed this cycle.
REQ-013 wr_busy  out  1  burst in progress.
REQ-014 wr_end  out  1  one-cycle completion pulse.
REQ-015 The app-side write-data ports SHALL be: app_wdf_wren out 1; app_wdf_data out DATA_W; app_wdf_mask out MASK_W; app_wdf_end out 1; app_wdf_rdy in 1.
REQ-016 The app-side command ports SHALL be: app_en out 1; app_rdy in 1; app_addr out ADDR_W; app_cmd out 3.

Function
REQ-017 The FSM SHALL have states IDLE, WRITE and DONE.
REQ-018 IDLE->WRITE SHALL occur on wr_cmd_start=1 with wr_cmd_bl!=0; in that same edge the block latches bl, addr and mask.
REQ-019 wr_cmd_start SHALL be ignored when wr_cmd_bl=0 or when the state is not IDLE.
REQ-020 WRITE->DONE SHALL occur when the last data beat and the last command have both been accepted.
REQ-021 DONE->IDLE SHALL occur unconditionally after one cycle.
REQ-022 wr_end SHALL be 1 exactly in DONE; wr_busy SHALL be 1 in WRITE and DONE.
REQ-023 Data channel: app_wdf_wren SHALL be 1 throughout WRITE until the beat with data_cnt=bl-1 is accepted, and 0 from the next cycle.
REQ-024 data_req SHALL equal app_wdf_wren & app_wdf_rdy, combinationally.
REQ-025 app_wdf_data SHALL equal data_in, combinationally (zero latency).
REQ-026 app_wdf_mask SHALL equal the latched mask while app_wdf_wren=1, and 0 otherwise.
REQ-027 app_wdf_end SHALL equal app_wdf_wren, since each beat is one full burst.
REQ-028 data_cnt SHALL increment on each data_req and clear on entry to IDLE.
REQ-029 Command channel: app_en SHALL be 1 in WRITE when cmd_cnt < data_cnt and cmd_cnt < bl, so commands never lead their data.
REQ-030 A command SHALL be accepted when app_en & app_rdy; cmd_cnt then increments.
REQ-031 app_addr SHALL equal start address + cmd_cnt*ADDR_STEP, modulo 2^ADDR_W, so the address wraps silently past the top.
REQ-032 app_addr SHALL hold its value while app_en=1 and app_rdy=0.
REQ-033 app_cmd SHALL be the constant 3'b000 (write).
REQ-034 The data and command channels SHALL run independently, and stalls on either ready input SHALL be tolerated indefinitely.
REQ-035 Simultaneous last-data and last-command acceptance in one cycle SHALL go to DONE on the next edge.
REQ-036 Counters SHALL be BL_W+1 bits wide so that bl = 2^BL_W-1 does not overflow.

Reset
REQ-037 rst=1 SHALL, asynchronously and at any time including mid-burst, force state IDLE and clear all counters and latched fields.
REQ-038 Under reset, outputs SHALL be: data_req=0, wr_busy=0, wr_end=0, app_wdf_wren=0, app_wdf_mask=0, app_wdf_end=0, app_en=0, app_addr=0.
REQ-039 After reset, commands already issued are not retried.
REQ-040 After rst deasserts, the block SHALL accept a new wr_cmd_start on the first edge.

Verification
REQ-041 Directed scenarios:
- Start bl=4, addr=0x100, both readies held 1 -> 4 data_req pulses; app_addr 0x100, 0x108, 0x110, 0x118; single wr_end; wr_busy low after.
- bl=3 with app_rdy=0 for 5 cycles -> all 3 data beats taken; app_addr held at start value; 3 commands issued after ready; wr_end follows the last command.
- app_wdf_rdy toggling 1/0, bl=5 -> exactly 5 data_req; app_en never asserted with cmd_cnt >= data_cnt.
- addr=2^28-8, bl=2 -> app_addr 0x FFFFFF8, then 0x0000000.
- wr_cmd_start during busy, and wr_cmd_start with bl=0 -> both ignored; no extra beats, commands or wr_end.
- rst pulse mid-burst (after 2 of 6 beats) -> all outputs 0 immediately; a new bl=1 burst then completes normally.

Source files
------------

// File: rtl/ddr_wr_burst_ctrl.sv
// Write-burst sequencer for a DDR controller app interface: streams user beats
// onto the write-data channel and issues one write command per beat.
module ddr_wr_burst_ctrl #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 28,
    parameter int BL_W      = 7,
    parameter int ADDR_STEP = 8,
    localparam int MASK_W   = DATA_W / 8
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              wr_cmd_start,
    input  logic [BL_W-1:0]   wr_cmd_bl,
    input  logic [ADDR_W-1:0] wr_cmd_addr,
    input  logic [MASK_W-1:0] wr_cmd_mask,
    input  logic [DATA_W-1:0] data_in,
    output logic              data_req,
    output logic              wr_busy,
    output logic              wr_end,
    output logic              app_wdf_wren,
    output logic [DATA_W-1:0] app_wdf_data,
    output logic [MASK_W-1:0] app_wdf_mask,
    output logic              app_wdf_end,
    input  logic              app_wdf_rdy,
    output logic              app_en,
    input  logic              app_rdy,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd
);

    localparam int CNT_W = BL_W + 1;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [BL_W-1:0]   bl_q, bl_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  data_cnt_q, data_cnt_d;
    logic [CNT_W-1:0]  cmd_cnt_q, cmd_cnt_d;
    logic              wren_q, wren_d;
    logic              busy_q, busy_d;
    logic              end_q, end_d;

    logic [CNT_W-1:0]  blExt;
    logic              dataAcc;
    logic              cmdAcc;

    assign blExt = {1'b0, bl_q};

    // Commands trail their data: a command may only go out for a beat already taken.
    assign app_en   = (state_q == WRITE) && (cmd_cnt_q < data_cnt_q) && (cmd_cnt_q < blExt);
    assign dataAcc  = wren_q & app_wdf_rdy;
    assign cmdAcc   = app_en & app_rdy;

    assign data_req     = dataAcc;
    assign app_wdf_wren = wren_q;
    assign app_wdf_end  = wren_q;
    assign app_wdf_data = data_in;
    assign app_wdf_mask = wren_q ? mask_q : '0;
    assign app_addr     = addr_q + (ADDR_W'(cmd_cnt_q) * ADDR_W'(ADDR_STEP));
    assign app_cmd      = 3'b000;
    assign wr_busy      = busy_q;
    assign wr_end       = end_q;

    always_comb begin
        state_d    = state_q;
        bl_d       = bl_q;
        addr_d     = addr_q;
        mask_d     = mask_q;
        data_cnt_d = data_cnt_q;
        cmd_cnt_d  = cmd_cnt_q;
        wren_d     = wren_q;
        busy_d     = busy_q;
        end_d      = end_q;
        case (state_q)
            IDLE: begin
                if (wr_cmd_start && (wr_cmd_bl != '0)) begin
                    state_d    = WRITE;
                    bl_d       = wr_cmd_bl;
                    addr_d     = wr_cmd_addr;
                    mask_d     = wr_cmd_mask;
                    data_cnt_d = '0;
                    cmd_cnt_d  = '0;
                    wren_d     = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            WRITE: begin
                if (dataAcc) begin
                    data_cnt_d = data_cnt_q + CNT_W'(1);
                    if ((data_cnt_q + CNT_W'(1)) == blExt) begin
                        wren_d = 1'b0;
                    end
                end
                if (cmdAcc) begin
                    cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
                end
                if ((data_cnt_d == blExt) && (cmd_cnt_d == blExt)) begin
                    state_d = DONE;
                    end_d   = 1'b1;
                end
            end
            DONE: begin
                state_d    = IDLE;
                end_d      = 1'b0;
                busy_d     = 1'b0;
                wren_d     = 1'b0;
                data_cnt_d = '0;
                cmd_cnt_d  = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bl_q       <= '0;
            addr_q     <= '0;
            mask_q     <= '0;
            data_cnt_q <= '0;
            cmd_cnt_q  <= '0;
            wren_q     <= 1'b0;
            busy_q     <= 1'b0;
            end_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bl_q       <= bl_d;
            addr_q     <= addr_d;
            mask_q     <= mask_d;
            data_cnt_q <= data_cnt_d;
            cmd_cnt_q  <= cmd_cnt_d;
            wren_q     <= wren_d;
            busy_q     <= busy_d;
            end_q      <= end_d;
        end
    end

endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// Bench for ddr_wr_burst_ctrl: table-driven bursts with randomized ready stalls,
// checked against a beat/command counting model, plus reset and bl=0 sequences.
module tb_ddr_wr_burst_ctrl;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 28;
    localparam int BL_W   = 7;
    localparam int MASK_W = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              wrCmdStart;
    logic [BL_W-1:0]   wrCmdBl;
    logic [ADDR_W-1:0] wrCmdAddr;
    logic [MASK_W-1:0] wrCmdMask;
    logic [DATA_W-1:0] dataIn;
    logic              dataReq;
    logic              wrBusy;
    logic              wrEnd;
    logic              appWdfWren;
    logic [DATA_W-1:0] appWdfData;
    logic [MASK_W-1:0] appWdfMask;
    logic              appWdfEnd;
    logic              appWdfRdy;
    logic              appEn;
    logic              appRdy;
    logic [ADDR_W-1:0] appAddr;
    logic [2:0]        appCmd;

    int testsRun  = 0;
    int failCount = 0;

    typedef struct {
        int                bl;
        logic [ADDR_W-1:0] addr;
        logic [MASK_W-1:0] mask;
        int                wdfPct;
        int                appPct;
        int                appStall;
        bit                noise;
    } vec_t;

    vec_t vecs[$];

    ddr_wr_burst_ctrl dut (
        .sclk         (clk),
        .rst          (rst),
        .wr_cmd_start (wrCmdStart),
        .wr_cmd_bl    (wrCmdBl),
        .wr_cmd_addr  (wrCmdAddr),
        .wr_cmd_mask  (wrCmdMask),
        .data_in      (dataIn),
        .data_req     (dataReq),
        .wr_busy      (wrBusy),
        .wr_end       (wrEnd),
        .app_wdf_wren (appWdfWren),
        .app_wdf_data (appWdfData),
        .app_wdf_mask (appWdfMask),
        .app_wdf_end  (appWdfEnd),
        .app_wdf_rdy  (appWdfRdy),
        .app_en       (appEn),
        .app_rdy      (appRdy),
        .app_addr     (appAddr),
        .app_cmd      (appCmd)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic wdfRdy, input logic aRdy);
        appWdfRdy = wdfRdy;
        appRdy    = aRdy;
        dataIn    = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic checkAllIdle(input string tag);
        checkOutput({tag, ".data_req"}, dataReq, 0);
        checkOutput({tag, ".wr_busy"}, wrBusy, 0);
        checkOutput({tag, ".wr_end"}, wrEnd, 0);
        checkOutput({tag, ".wdf_wren"}, appWdfWren, 0);
        checkOutput({tag, ".wdf_mask"}, appWdfMask, 0);
        checkOutput({tag, ".wdf_end"}, appWdfEnd, 0);
        checkOutput({tag, ".app_en"}, appEn, 0);
        checkOutput({tag, ".app_addr"}, appAddr, 0);
    endtask

    // Entered and left at a drive point (1 time unit after a rising edge).
    task automatic runBurst(input vec_t v);
        int beats = 0;
        int cmds  = 0;
        int ends  = 0;
        int cyc   = 0;
        int budget;
        logic wdf;
        logic ar;
        logic [ADDR_W-1:0] expAddr;
        budget = 60 * v.bl + 200;

        wrCmdStart = 1'b1;
        wrCmdBl    = BL_W'(v.bl);
        wrCmdAddr  = v.addr;
        wrCmdMask  = v.mask;
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        checkOutput("preStart.wr_busy", wrBusy, 0);
        @(posedge clk);
        #1;
        wrCmdStart = 1'b0;

        while (ends == 0 && cyc < budget) begin
            if (v.wdfPct < 0) wdf = (cyc % 2 == 0);
            else              wdf = ($urandom_range(99) < v.wdfPct);
            ar = (cyc >= v.appStall) && ($urandom_range(99) < v.appPct);
            applyStimulus(wdf, ar);
            if (v.noise) begin
                wrCmdStart = $urandom_range(1);
                wrCmdBl    = BL_W'($urandom_range(1, 100));
                wrCmdAddr  = ADDR_W'($urandom);
            end
            @(negedge clk);
            checkOutput("data_req", dataReq, appWdfWren & appWdfRdy);
            checkOutput("wdf_data", appWdfData, dataIn);
            checkOutput("wdf_end", appWdfEnd, appWdfWren);
            checkOutput("wdf_wren", appWdfWren, beats < v.bl);
            checkOutput("wdf_mask", appWdfMask, (beats < v.bl) ? v.mask : '0);
            checkOutput("app_en", appEn, (cmds < beats) && (cmds < v.bl));
            checkOutput("app_cmd", appCmd, 3'b000);
            checkOutput("wr_busy", wrBusy, 1);
            checkOutput("wr_end", wrEnd, cmds == v.bl);
            if (appEn) begin
                expAddr = v.addr + ADDR_W'(cmds * 8);
                checkOutput("app_addr", appAddr, expAddr);
            end
            if (dataReq) beats++;
            if (appEn && appRdy) cmds++;
            if (wrEnd) ends++;
            cyc++;
            @(posedge clk);
            #1;
        end
        wrCmdStart = 1'b0;
        checkOutput("burstTimeout", ends, 1);
        checkOutput("beatCount", beats, v.bl);
        checkOutput("cmdCount", cmds, v.bl);
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        checkOutput("after.wr_busy", wrBusy, 0);
        checkOutput("after.wr_end", wrEnd, 0);
        checkOutput("after.wdf_wren", appWdfWren, 0);
        checkOutput("after.app_en", appEn, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        int beats;
        int guard;

        rst        = 1'b1;
        wrCmdStart = 1'b0;
        wrCmdBl    = '0;
        wrCmdAddr  = '0;
        wrCmdMask  = '0;
        applyStimulus(1'b1, 1'b1);
        #12;
        checkAllIdle("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        vecs.push_back('{4,   28'h0000100, 16'h0000, 100, 100, 0, 1'b0});
        vecs.push_back('{3,   28'h0000200, 16'h00F0, 100, 100, 5, 1'b0});
        vecs.push_back('{5,   28'h0000300, 16'hA5A5, -1,  100, 0, 1'b0});
        vecs.push_back('{2,   28'hFFFFFF8, 16'h0001, 100, 100, 0, 1'b0});
        vecs.push_back('{6,   28'h0001000, 16'h1234, 100, 100, 0, 1'b1});
        vecs.push_back('{1,   28'h0002000, 16'hFFFF, 50,  50,  2, 1'b0});
        vecs.push_back('{127, 28'hFFFFE00, 16'h8001, 100, 100, 0, 1'b0});
        vecs.push_back('{127, 28'h0003000, 16'h00FF, 40,  60,  3, 1'b1});
        for (int i = 0; i < 16; i++) begin
            v.bl       = $urandom_range(1, 24);
            v.addr     = ADDR_W'($urandom);
            v.mask     = MASK_W'($urandom);
            v.wdfPct   = $urandom_range(30, 100);
            v.appPct   = $urandom_range(30, 100);
            v.appStall = $urandom_range(0, 6);
            v.noise    = 1'($urandom_range(1));
            vecs.push_back(v);
        end

        foreach (vecs[i]) runBurst(vecs[i]);

        // A start request with zero beats must not launch anything.
        wrCmdStart = 1'b1;
        wrCmdBl    = '0;
        wrCmdAddr  = 28'h0000400;
        @(posedge clk);
        #1;
        wrCmdStart = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bl0.wr_busy", wrBusy, 0);
            checkOutput("bl0.wdf_wren", appWdfWren, 0);
            checkOutput("bl0.app_en", appEn, 0);
            checkOutput("bl0.wr_end", wrEnd, 0);
            @(posedge clk);
            #1;
        end

        // Reset lands after two of six beats have been taken.
        wrCmdStart = 1'b1;
        wrCmdBl    = BL_W'(6);
        wrCmdAddr  = 28'h0000500;
        wrCmdMask  = 16'h0F0F;
        applyStimulus(1'b1, 1'b0);
        @(posedge clk);
        #1;
        wrCmdStart = 1'b0;
        beats = 0;
        guard = 0;
        while (beats < 2 && guard < 20) begin
            @(negedge clk);
            if (dataReq) beats++;
            guard++;
            @(posedge clk);
        end
        checkOutput("rstMid.beatsBefore", beats, 2);
        #2;
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1);
        #1;
        checkAllIdle("rstMid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        v = '{1, 28'h0000600, 16'h0003, 100, 100, 0, 1'b0};
        runBurst(v);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
